// File: rtl/vt52_pkg.sv
// vt52_pkg: shared VT52 character constants, special-key indices and the
// encoder sequencer state type.
//   No ports. Import with `import vt52_pkg::*;`.
package vt52_pkg;

   // Sequence framing bytes
   localparam logic [7:0] CHAR_ESC   = 8'h1B;
   localparam logic [7:0] CHAR_SLASH = 8'h2F;

   // Final bytes of the two-byte special-key sequences
   localparam logic [7:0] CHAR_A = 8'h41;
   localparam logic [7:0] CHAR_B = 8'h42;
   localparam logic [7:0] CHAR_C = 8'h43;
   localparam logic [7:0] CHAR_D = 8'h44;
   localparam logic [7:0] CHAR_H = 8'h48;
   localparam logic [7:0] CHAR_P = 8'h50;
   localparam logic [7:0] CHAR_Q = 8'h51;
   localparam logic [7:0] CHAR_R = 8'h52;

   // Special-key indices carried in key_code[2:0]
   localparam logic [2:0] KEY_UP    = 3'd0;
   localparam logic [2:0] KEY_DOWN  = 3'd1;
   localparam logic [2:0] KEY_RIGHT = 3'd2;
   localparam logic [2:0] KEY_LEFT  = 3'd3;
   localparam logic [2:0] KEY_HOME  = 3'd4;
   localparam logic [2:0] KEY_PF1   = 3'd5;
   localparam logic [2:0] KEY_PF2   = 3'd6;
   localparam logic [2:0] KEY_PF3   = 3'd7;

   // Longest sequence the encoder emits (identify reply)
   localparam int unsigned SEQ_MAX = 3;

   typedef enum logic {
      ST_IDLE,
      ST_SEND
   } state_e;

endpackage

// File: rtl/keyboard_encoder_if.sv
// keyboard_encoder_if: key-event input and byte-output handshakes of the
// keyboard encoder.
//   key_code/key_special/key_valid/key_ready : key event from the scanner
//   ident_req                                : identify request pulse
//   out_data/out_valid/out_ready             : byte stream to the transmitter
//   modport slave  : the encoder
//   modport master : the surrounding scanner/command path/transmitter
interface keyboard_encoder_if;
   logic [7:0] key_code;
   logic       key_special;
   logic       key_valid;
   logic       key_ready;
   logic       ident_req;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;

   modport slave (
      input  key_code,
      input  key_special,
      input  key_valid,
      output key_ready,
      input  ident_req,
      output out_data,
      output out_valid,
      input  out_ready
   );

   modport master (
      output key_code,
      output key_special,
      output key_valid,
      input  key_ready,
      output ident_req,
      input  out_data,
      input  out_valid,
      output out_ready
   );
endinterface

// File: rtl/special_key_map.sv
// special_key_map: combinational map from a 3-bit special-key index to the
// final byte of its VT52 ESC sequence.
//   key_idx    in  3 : special-key index (KEY_UP..KEY_PF3)
//   final_char out 8 : byte sent after ESC
module special_key_map
   import vt52_pkg::*;
(
   input  logic [2:0] key_idx,
   output logic [7:0] final_char
);

   always_comb begin
      final_char = CHAR_A;
      unique case (key_idx)
         KEY_UP:    final_char = CHAR_A;
         KEY_DOWN:  final_char = CHAR_B;
         KEY_RIGHT: final_char = CHAR_C;
         KEY_LEFT:  final_char = CHAR_D;
         KEY_HOME:  final_char = CHAR_H;
         KEY_PF1:   final_char = CHAR_P;
         KEY_PF2:   final_char = CHAR_Q;
         KEY_PF3:   final_char = CHAR_R;
         default:   final_char = CHAR_A;
      endcase
   end

endmodule

// File: rtl/keyboard_encoder.sv
// keyboard_encoder: turns key events and identify requests into the VT52
// byte stream sent to the host.
//   clk  in  : system clock, rising edge
//   clr  in  : asynchronous active-high reset
//   kbd  slave modport of keyboard_encoder_if:
//      key_code/key_special/key_valid/key_ready : key event handshake
//      ident_req                                : identify request pulse
//      out_data/out_valid/out_ready             : byte output handshake
module keyboard_encoder
   import vt52_pkg::*;
#(
   parameter logic [7:0] IDENT_CHAR = 8'h4B,
   parameter logic [7:0] ESC_CHAR   = 8'h1B
) (
   input  logic               clk,
   input  logic               clr,
   keyboard_encoder_if.slave  kbd
);

   state_e                    state_q, state_d;
   logic [SEQ_MAX-1:0][7:0]   seq_q, seq_d;
   logic [1:0]                idx_q, idx_d;
   logic [1:0]                len_q, len_d;
   logic                      ident_pend_q, ident_pend_d;
   // Set while the sequence being sent is an identify reply, so that
   // requests arriving during it are merged instead of queued again.
   logic                      ident_busy_q, ident_busy_d;

   logic [7:0]                mapped_char;
   logic                      key_ready;
   logic                      key_fire;
   logic                      load_ident;

   special_key_map u_special_key_map (
      .key_idx    (kbd.key_code[2:0]),
      .final_char (mapped_char)
   );

   // clr is in the term so the upstream sees not-ready while reset is held
   assign key_ready = (state_q == ST_IDLE) && !ident_pend_q && !kbd.ident_req && !clr;
   assign key_fire  = kbd.key_valid && key_ready;

   assign kbd.key_ready = key_ready;
   assign kbd.out_valid = (state_q == ST_SEND);
   assign kbd.out_data  = (state_q == ST_SEND) ? seq_q[idx_q] : 8'h00;

   always_comb begin
      state_d      = state_q;
      seq_d        = seq_q;
      idx_d        = idx_q;
      len_d        = len_q;
      ident_busy_d = ident_busy_q;
      load_ident   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (ident_pend_q || kbd.ident_req) begin
               seq_d[0]     = ESC_CHAR;
               seq_d[1]     = CHAR_SLASH;
               seq_d[2]     = IDENT_CHAR;
               len_d        = 2'd3;
               idx_d        = 2'd0;
               ident_busy_d = 1'b1;
               load_ident   = 1'b1;
               state_d      = ST_SEND;
            end else if (key_fire) begin
               if (kbd.key_special) begin
                  seq_d[0] = ESC_CHAR;
                  seq_d[1] = mapped_char;
                  len_d    = 2'd2;
               end else begin
                  seq_d[0] = kbd.key_code;
                  len_d    = 2'd1;
               end
               idx_d        = 2'd0;
               ident_busy_d = 1'b0;
               state_d      = ST_SEND;
            end
         end
         ST_SEND: begin
            if (kbd.out_ready) begin
               if (idx_q == len_q - 2'd1) begin
                  idx_d        = 2'd0;
                  ident_busy_d = 1'b0;
                  state_d      = ST_IDLE;
               end else begin
                  idx_d = idx_q + 2'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      ident_pend_d = ident_pend_q;
      if (load_ident) begin
         ident_pend_d = 1'b0;
      end else if (kbd.ident_req && !((state_q == ST_SEND) && ident_busy_q)) begin
         ident_pend_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q      <= ST_IDLE;
         seq_q        <= '0;
         idx_q        <= 2'd0;
         len_q        <= 2'd0;
         ident_pend_q <= 1'b0;
         ident_busy_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         seq_q        <= seq_d;
         idx_q        <= idx_d;
         len_q        <= len_d;
         ident_pend_q <= ident_pend_d;
         ident_busy_q <= ident_busy_d;
      end
   end

endmodule

// File: tb/tb_keyboard_encoder.sv
// tb_keyboard_encoder: scoreboard bench for keyboard_encoder. A reference
// model predicts the byte stream into a queue; a monitor pops and compares on
// every output handshake and checks key_ready/out_valid each cycle.
module tb_keyboard_encoder;

   logic clk = 1'b0;
   logic clr = 1'b1;
   int   checks = 0;
   int   failures = 0;

   keyboard_encoder_if kbd ();

   keyboard_encoder #(
      .IDENT_CHAR (8'h4B),
      .ESC_CHAR   (8'h1B)
   ) dut (
      .clk (clk),
      .clr (clr),
      .kbd (kbd)
   );

   always #5 clk = ~clk;

   // Reference model state
   logic [7:0] exp_q[$];
   int         m_rem = 0;       // bytes of the current sequence not yet sent
   bit         m_pend = 0;      // identify requested, not yet loaded
   bit         m_sid = 0;       // current sequence is an identify reply
   bit         key_taken = 0;   // key accepted on the most recent edge
   logic [7:0] keymap [8] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h48, 8'h50, 8'h51, 8'h52};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference model: sequence-level view of what the encoder must emit
   always @(posedge clk or posedge clr) begin
      if (clr) begin
         m_rem = 0;
         m_pend = 0;
         m_sid = 0;
         key_taken = 0;
         exp_q.delete();
      end else begin
         bit loaded_id;
         bit sid_before;
         loaded_id = 0;
         sid_before = m_sid;
         key_taken = 0;
         if (m_rem != 0) begin
            if (kbd.out_ready) begin
               m_rem--;
               if (m_rem == 0) m_sid = 0;
            end
         end else if (m_pend || kbd.ident_req) begin
            exp_q.push_back(8'h1B);
            exp_q.push_back(8'h2F);
            exp_q.push_back(8'h4B);
            m_rem = 3;
            m_sid = 1;
            m_pend = 0;
            loaded_id = 1;
         end else if (kbd.key_valid) begin
            key_taken = 1;
            if (kbd.key_special) begin
               exp_q.push_back(8'h1B);
               exp_q.push_back(keymap[kbd.key_code[2:0]]);
               m_rem = 2;
            end else begin
               exp_q.push_back(kbd.key_code);
               m_rem = 1;
            end
         end
         if (kbd.ident_req && !loaded_id && !sid_before) m_pend = 1;
      end
   end

   // Monitor
   bit         stall_prev = 0;
   logic [7:0] data_prev = 8'h00;
   always @(negedge clk) begin
      if (clr) begin
         stall_prev <= 0;
      end else begin
         check("key_ready", 32'(kbd.key_ready),
               32'((m_rem == 0) && !m_pend && !kbd.ident_req));
         check("out_valid", 32'(kbd.out_valid), 32'(m_rem != 0));
         if (stall_prev) begin
            check("stall_valid", 32'(kbd.out_valid), 32'd1);
            check("stall_data", 32'(kbd.out_data), 32'(data_prev));
         end
         if (kbd.out_valid && kbd.out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_byte", 32'(kbd.out_data), 32'hFFFF_FFFF);
            end else begin
               check("out_data", 32'(kbd.out_data), 32'(exp_q.pop_front()));
            end
         end
         stall_prev <= kbd.out_valid && !kbd.out_ready;
         data_prev  <= kbd.out_data;
      end
   end

   task automatic cyc(input bit ir, input bit ordy);
      @(posedge clk);
      #1;
      if (kbd.key_valid && key_taken) kbd.key_valid = 1'b0;
      kbd.ident_req = ir;
      kbd.out_ready = ordy;
   endtask

   task automatic offer(input logic [7:0] code, input bit special);
      kbd.key_code    = code;
      kbd.key_special = special;
      kbd.key_valid   = 1'b1;
   endtask

   task automatic wait_taken();
      int n;
      n = 0;
      while (kbd.key_valid && n < 60) begin
         cyc(1'b0, 1'b1);
         n++;
      end
      if (kbd.key_valid) begin
         check("key_accept_timeout", 32'd0, 32'd1);
         kbd.key_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((m_rem != 0 || m_pend || exp_q.size() != 0) && n < 100) begin
         cyc(1'b0, 1'b1);
         n++;
      end
      check("drain_done", 32'(exp_q.size()), 32'd0);
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b1);
   endtask

   initial begin
      kbd.key_code    = 8'h00;
      kbd.key_special = 1'b0;
      kbd.key_valid   = 1'b0;
      kbd.ident_req   = 1'b0;
      kbd.out_ready   = 1'b0;
      #12;
      check("rst_out_valid", 32'(kbd.out_valid), 32'd0);
      check("rst_out_data", 32'(kbd.out_data), 32'h00);
      check("rst_key_ready", 32'(kbd.key_ready), 32'd0);
      @(posedge clk);
      #1 clr = 1'b0;
      cyc(1'b0, 1'b1);

      // Plain key
      offer(8'h61, 1'b0);
      wait_taken();
      drain();

      // Special key: up
      offer(8'h00, 1'b1);
      wait_taken();
      drain();

      // Identify with stalls
      cyc(1'b1, 1'b1);
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b1);
      drain();

      // Identify and plain key in the same cycle
      cyc(1'b1, 1'b1);
      offer(8'h62, 1'b0);
      wait_taken();
      drain();

      // Identify requests while ESC C is sending
      offer(8'hFA, 1'b1);
      wait_taken();
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b1);
      drain();

      // clr after first byte of identify
      cyc(1'b1, 1'b1);
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b0);
      #2 clr = 1'b1;
      #1;
      check("clr_out_valid", 32'(kbd.out_valid), 32'd0);
      check("clr_key_ready", 32'(kbd.key_ready), 32'd0);
      @(posedge clk);
      #1 clr = 1'b0;
      kbd.out_ready = 1'b1;
      cyc(1'b0, 1'b1);
      check("post_clr_key_ready", 32'(kbd.key_ready), 32'd1);
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b1);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom % 25) == 0, ($urandom % 4) != 0);
         if (!kbd.key_valid && ($urandom % 3) == 0) begin
            offer(8'($urandom), 1'($urandom));
         end
      end
      kbd.key_valid = 1'b0;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
